// File: rtl/buzzer_sos_pattern_gen_pkg.sv
// Shared types, Morse timing constants and symbol-table lookups for the SOS buzzer.
// A pattern is nine symbols: dot dot dot, dash dash dash, dot dot dot.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  typedef logic [3:0]  sym_idx_t;
  typedef logic [27:0] cnt_t;

  localparam int SOS_SYMS         = 9;
  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int SYM_GAP_UNITS    = 1;
  localparam int LETTER_GAP_UNITS = 3;

  localparam sym_idx_t LAST_SYM = sym_idx_t'(SOS_SYMS - 1);

  // Symbols 3..5 form the "O" and are dashes; the rest are dots.
  function automatic cnt_t on_len(input sym_idx_t idx);
    cnt_t len;
    len = cnt_t'(DOT_UNITS);
    if (idx >= 4'd3 && idx <= 4'd5) begin
      len = cnt_t'(DASH_UNITS);
    end
    return len;
  endfunction

  // Silence after a symbol; the last symbol never reaches OFF.
  function automatic cnt_t gap_len(input sym_idx_t idx);
    cnt_t len;
    len = cnt_t'(SYM_GAP_UNITS);
    if (idx == 4'd2 || idx == 4'd5) begin
      len = cnt_t'(LETTER_GAP_UNITS);
    end
    return len;
  endfunction

endpackage

// File: rtl/buzzer_sos_pattern_gen_if.sv
// Start pulse in, buzzer drive and status out; master is the SOS period controller side.
interface buzzer_sos_pattern_gen_if;
  import buzzer_pkg::*;

  logic     SOS_En_Sig;
  logic     Pin_Out;
  logic     Busy;
  logic     Done;
  sym_idx_t Sym_Idx;

  modport master (
    output SOS_En_Sig,
    input  Pin_Out,
    input  Busy,
    input  Done,
    input  Sym_Idx
  );

  modport slave (
    input  SOS_En_Sig,
    output Pin_Out,
    output Busy,
    output Done,
    output Sym_Idx
  );

endinterface

// File: rtl/buzzer_sos_pattern_gen_tone_gen.sv
// Square-wave tone for a passive buzzer; output is forced low whenever not enabled.
// TONE_HALF = 0 gives a steady high while enabled, for an active buzzer.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter cnt_t TONE_HALF = 28'd25_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic enable,
  input  logic restart,
  output logic tone
);

  cnt_t cnt_q, cnt_d;
  logic tone_q, tone_d;

  // enable/restart describe the cycle after the coming edge, so tone_q lines up with the FSM state.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!enable) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (restart) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (TONE_HALF == '0) begin
      tone_d = 1'b1;
    end else if (cnt_q == TONE_HALF - 28'd1) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + 28'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/buzzer_sos_pattern_gen.sv
// Plays one Morse SOS on the buzzer pin for each start pulse accepted while idle.
// Sequencing lives here; the tone waveform comes from buzzer_tone_gen.
module buzzer_sos_pattern_gen
  import buzzer_pkg::*;
#(
  parameter cnt_t T_UNIT    = 28'd5_000_000,
  parameter cnt_t TONE_HALF = 28'd25_000
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  buzzer_sos_pattern_gen_if.slave   bus
);

  state_t   state_q, state_d;
  sym_idx_t sym_q, sym_d;
  cnt_t     cyc_q, cyc_d;
  cnt_t     unit_q, unit_d;
  logic     busy_q, busy_d;
  logic     done_q, done_d;

  cnt_t     seg_len;
  logic     unit_last;
  logic     seg_last;
  logic     tone_enable;
  logic     tone_restart;
  logic     tone;

  assign seg_len   = (state_q == ON) ? on_len(sym_q) : gap_len(sym_q);
  assign unit_last = (cyc_q == T_UNIT - 28'd1);
  assign seg_last  = unit_last && (unit_q == seg_len - 28'd1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.SOS_En_Sig) begin
          state_d = ON;
          sym_d   = '0;
          cyc_d   = '0;
          unit_d  = '0;
        end
      end

      ON, OFF: begin
        if (!unit_last) begin
          cyc_d = cyc_q + 28'd1;
        end else begin
          cyc_d = '0;
          if (!seg_last) begin
            unit_d = unit_q + 28'd1;
          end else begin
            unit_d = '0;
            if (state_q == OFF) begin
              state_d = ON;
              sym_d   = sym_q + 4'd1;
            end else if (sym_q == LAST_SYM) begin
              state_d = IDLE;
              sym_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = OFF;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        sym_d   = '0;
        cyc_d   = '0;
        unit_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  assign busy_d       = (state_d != IDLE);
  assign tone_enable  = (state_d == ON);
  assign tone_restart = tone_enable && (state_q != ON);

  // NOTE: reset is synchronous (sampled only at the clock edge) and sequential state uses <= only.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      sym_q   <= '0;
      cyc_q   <= '0;
      unit_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  buzzer_tone_gen #(
    .TONE_HALF (TONE_HALF)
  ) u_tone (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .enable  (tone_enable),
    .restart (tone_restart),
    .tone    (tone)
  );

  assign bus.Pin_Out = tone;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Sym_Idx = sym_q;

endmodule

// File: tb/tb_buzzer_sos_pattern_gen.sv
// Self-checking bench: three DUT configurations checked against a waveform model
// built from the Morse symbol rules (per-cycle expected pin level and symbol index).
module tb_buzzer_sos_pattern_gen;

  logic clk;
  logic rst_n;
  logic en      [3];
  logic pin_w   [3];
  logic busy_w  [3];
  logic done_w  [3];
  logic [3:0] sym_w [3];

  int tu [3] = '{4, 8, 1};
  int th [3] = '{0, 2, 0};

  int tests_run;
  int tests_failed;

  bit m_pin [$];
  int m_sym [$];

  buzzer_sos_pattern_gen_if if_a ();
  buzzer_sos_pattern_gen_if if_b ();
  buzzer_sos_pattern_gen_if if_c ();

  assign if_a.SOS_En_Sig = en[0];
  assign if_b.SOS_En_Sig = en[1];
  assign if_c.SOS_En_Sig = en[2];

  assign pin_w[0] = if_a.Pin_Out;  assign busy_w[0] = if_a.Busy;
  assign done_w[0] = if_a.Done;    assign sym_w[0]  = if_a.Sym_Idx;
  assign pin_w[1] = if_b.Pin_Out;  assign busy_w[1] = if_b.Busy;
  assign done_w[1] = if_b.Done;    assign sym_w[1]  = if_b.Sym_Idx;
  assign pin_w[2] = if_c.Pin_Out;  assign busy_w[2] = if_c.Busy;
  assign done_w[2] = if_c.Done;    assign sym_w[2]  = if_c.Sym_Idx;

  buzzer_sos_pattern_gen #(.T_UNIT(28'd4), .TONE_HALF(28'd0)) dut_a (
    .CLK (clk), .RSTn (rst_n), .bus (if_a.slave));
  buzzer_sos_pattern_gen #(.T_UNIT(28'd8), .TONE_HALF(28'd2)) dut_b (
    .CLK (clk), .RSTn (rst_n), .bus (if_b.slave));
  buzzer_sos_pattern_gen #(.T_UNIT(28'd1), .TONE_HALF(28'd0)) dut_c (
    .CLK (clk), .RSTn (rst_n), .bus (if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Expected Pin_Out/Sym_Idx for cycles 1..27*T after the accepted start pulse.
  task automatic build_model(input int t_unit, input int tone_half);
    m_pin.delete();
    m_sym.delete();
    for (int s = 0; s < 9; s++) begin
      int on_units;
      int gap_units;
      on_units  = (s >= 3 && s <= 5) ? 3 : 1;
      gap_units = (s == 8) ? 0 : ((s == 2 || s == 5) ? 3 : 1);
      for (int c = 0; c < on_units * t_unit; c++) begin
        m_pin.push_back((tone_half == 0) ? 1'b1 : (((c / tone_half) % 2) == 0));
        m_sym.push_back(s);
      end
      for (int c = 0; c < gap_units * t_unit; c++) begin
        m_pin.push_back(1'b0);
        m_sym.push_back(s);
      end
    end
  endtask

  // Entered at a falling edge with en[d] already high for the coming start edge.
  task automatic play(input int d, input int extra_at, input bit chain, input string name);
    int len;
    int busy_cnt;
    int pin_cnt;
    int exp_pin_cnt;
    build_model(tu[d], th[d]);
    len = m_pin.size();
    busy_cnt = 0;
    pin_cnt = 0;
    exp_pin_cnt = 0;
    foreach (m_pin[i]) exp_pin_cnt += int'(m_pin[i]);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (busy_w[d] === 1'b1) busy_cnt++;
      if (pin_w[d] === 1'b1) pin_cnt++;
      if (k <= len) begin
        tests_run++;
        if (pin_w[d] !== m_pin[k-1]) begin
          tests_failed++;
          $display("FAIL %s pin cycle %0d: got %b expected %b", name, k, pin_w[d], m_pin[k-1]);
        end
        tests_run++;
        if (busy_w[d] !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s busy cycle %0d: got %b expected 1", name, k, busy_w[d]);
        end
        tests_run++;
        if (done_w[d] !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s done cycle %0d: got %b expected 0", name, k, done_w[d]);
        end
        tests_run++;
        if (sym_w[d] !== 4'(m_sym[k-1])) begin
          tests_failed++;
          $display("FAIL %s sym cycle %0d: got %0d expected %0d", name, k, sym_w[d], m_sym[k-1]);
        end
      end else begin
        tests_run++;
        if (done_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || pin_w[d] !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s done cycle %0d: got done=%b busy=%b pin=%b expected 1/0/0",
                   name, k, done_w[d], busy_w[d], pin_w[d]);
        end
      end
      en[d] = (k == extra_at) || (chain && k == len + 1);
    end
    tests_run++;
    if (busy_cnt != 27 * tu[d]) begin
      tests_failed++;
      $display("FAIL %s busy length: got %0d expected %0d", name, busy_cnt, 27 * tu[d]);
    end
    tests_run++;
    if (pin_cnt != exp_pin_cnt) begin
      tests_failed++;
      $display("FAIL %s pin high count: got %0d expected %0d", name, pin_cnt, exp_pin_cnt);
    end
  endtask

  // n idle cycles with all outputs quiet; optionally raise en[d] in the last one.
  task automatic idle_check(input int d, input int n, input string name, input bit pulse);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || pin_w[d] !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s idle cycle %0d: got busy=%b done=%b pin=%b expected 0/0/0",
                 name, i, busy_w[d], done_w[d], pin_w[d]);
      end
      en[d] = pulse && (i == n - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) en[d] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (pin_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || sym_w[d] !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset dut%0d: got pin=%b busy=%b done=%b sym=%0d expected all 0",
                 d, pin_w[d], busy_w[d], done_w[d], sym_w[d]);
      end
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) idle_check(d, 3, "reset_idle", 1'b0);
  endtask

  task automatic test_basic_timing();
    en[0] = 1'b1;
    play(0, 0, 1'b0, "basic");
    idle_check(0, 5, "basic_idle", 1'b0);
  endtask

  task automatic test_tone_shape();
    en[1] = 1'b1;
    play(1, 0, 1'b0, "tone");
    idle_check(1, 3, "tone_idle", 1'b0);
  endtask

  task automatic test_min_unit();
    en[2] = 1'b1;
    play(2, 0, 1'b0, "min_unit");
    idle_check(2, 3, "min_unit_idle", 1'b0);
  endtask

  task automatic test_back_to_back();
    en[0] = 1'b1;
    play(0, 50, 1'b1, "retrig_first");
    play(0, 0, 1'b0, "retrig_second");
    idle_check(0, 4, "retrig_idle", 1'b0);
  endtask

  task automatic test_reset_mid_dash();
    build_model(tu[0], th[0]);
    en[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tests_run++;
      if (pin_w[0] !== m_pin[k-1] || sym_w[0] !== 4'(m_sym[k-1])) begin
        tests_failed++;
        $display("FAIL mid_reset pre cycle %0d: got pin=%b sym=%0d expected %b/%0d",
                 k, pin_w[0], sym_w[0], m_pin[k-1], m_sym[k-1]);
      end
      en[0] = 1'b0;
      if (k == 40) rst_n = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if (pin_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || sym_w[0] !== 4'd0 || done_w[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset abort: got pin=%b busy=%b sym=%0d done=%b expected all 0",
               pin_w[0], busy_w[0], sym_w[0], done_w[0]);
    end
    rst_n = 1'b1;
    idle_check(0, 100, "mid_reset_quiet", 1'b1);
    play(0, 0, 1'b0, "mid_reset_restart");
  endtask

  // Start pulses every 200 cycles, as the period controller would issue them.
  task automatic test_periodic();
    en[0] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      play(0, 0, 1'b0, "periodic");
      idle_check(0, 91, "periodic_gap", p < 2);
    end
  endtask

  task automatic test_random();
    int  d;
    bit  ch;
    int  extra;
    d  = 0;
    ch = 1'b0;
    for (int it = 0; it < 6; it++) begin
      if (!ch) begin
        d = int'($urandom_range(0, 1));
        idle_check(d, int'($urandom_range(1, 20)), "rand_gap", 1'b1);
      end
      ch    = (it < 5) ? bit'($urandom_range(0, 1)) : 1'b0;
      extra = int'($urandom_range(0, 27 * tu[d]));
      play(d, extra, ch, "random");
    end
    idle_check(d, 3, "rand_idle", 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    for (int d = 0; d < 3; d++) en[d] = 1'b0;
    test_reset();
    test_basic_timing();
    test_tone_shape();
    test_min_unit();
    test_back_to_back();
    test_reset_mid_dash();
    test_periodic();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
